// File: rtl/sens_fifo_ctrl.sv
// sens_fifo_ctrl: gates AFE samples into the streaming FIFO, serves I2C
// data-register reads by popping it, drains it on flush, and keeps
// level / watermark / overflow / underflow status.
module sens_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sens_data_val,
  input  logic [DATA_WIDTH-1:0] sens_data,
  input  logic                  cfg_en,
  input  logic                  cfg_flush,
  input  logic                  cfg_clr_stat,
  input  logic [ADDR_WIDTH:0]   cfg_wmark,
  input  logic                  host_rd_req,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  output logic                  host_rd_valid,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  wmark_irq,
  output logic                  ovf_flag,
  output logic [7:0]            ovf_cnt,
  output logic                  udf_flag,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_CAPT  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] LVL_MAX = (ADDR_WIDTH+1)'(DEPTH);

  state_t                r_state;
  logic                  r_flush_pend;
  logic [DATA_WIDTH-1:0] r_host_rd_data;
  logic                  r_host_rd_valid;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_wmark_irq;
  logic                  r_ovf_flag;
  logic [7:0]            r_ovf_cnt;
  logic                  r_udf_flag;

  logic w_wr_en;
  logic w_rd_en;
  logic w_flush_go;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Strobes and status events decoded from the current state and inputs
  always_comb begin
    w_flush_go = cfg_flush | r_flush_pend;
    w_wr_en    = ~rst & sens_data_val & cfg_en & ~fifo_full & (r_state != ST_FLUSH);
    w_rd_en    = ~rst & ((r_state == ST_RD) | ((r_state == ST_FLUSH) & ~fifo_empty));
    w_ovf_evt  = ~rst & sens_data_val & cfg_en & fifo_full;
    w_udf_evt  = ~rst & (r_state == ST_IDLE) & ~w_flush_go & host_rd_req & fifo_empty;
  end

  // Read / flush state machine; a flush requested mid-read is parked in
  // r_flush_pend and taken from IDLE once the read has delivered its word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_flush_pend    <= 1'b0;
      r_host_rd_data  <= '0;
      r_host_rd_valid <= 1'b0;
    end else begin
      r_host_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_flush_go) begin
            r_state <= ST_FLUSH;
          end else if (host_rd_req) begin
            if (!fifo_empty) begin
              r_state <= ST_RD;
            end else begin
              r_host_rd_data  <= '0;
              r_host_rd_valid <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (cfg_flush) r_flush_pend <= 1'b1;
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          if (cfg_flush) r_flush_pend <= 1'b1;
          r_host_rd_data  <= fifo_rd_data;
          r_host_rd_valid <= 1'b1;
          r_state         <= ST_IDLE;
        end
        ST_FLUSH: begin
          // rd_en is ~fifo_empty here, so empty also means nothing is in flight
          if (fifo_empty) begin
            r_flush_pend <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Occupancy tracking; simultaneous push and pop cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else if (w_wr_en && !w_rd_en && (r_level != LVL_MAX)) begin
      r_level <= r_level + 1'b1;
    end else if (w_rd_en && !w_wr_en && (r_level != '0)) begin
      r_level <= r_level - 1'b1;
    end
  end

  // Watermark interrupt from the registered level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wmark_irq <= 1'b0;
    end else begin
      r_wmark_irq <= (cfg_wmark != '0) && (r_level >= cfg_wmark);
    end
  end

  // Overflow status; a new drop in the clear cycle wins and restarts the count at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_flag <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (w_ovf_evt) begin
      r_ovf_flag <= 1'b1;
      if (cfg_clr_stat)          r_ovf_cnt <= 8'd1;
      else if (r_ovf_cnt != '1)  r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end else if (cfg_clr_stat) begin
      r_ovf_flag <= 1'b0;
      r_ovf_cnt  <= '0;
    end
  end

  // Underflow status; event wins over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_udf_flag <= 1'b0;
    end else if (w_udf_evt) begin
      r_udf_flag <= 1'b1;
    end else if (cfg_clr_stat) begin
      r_udf_flag <= 1'b0;
    end
  end

  assign fifo_wr_en    = w_wr_en;
  assign fifo_wr_data  = sens_data;
  assign fifo_rd_en    = w_rd_en;
  assign host_rd_data  = r_host_rd_data;
  assign host_rd_valid = r_host_rd_valid;
  assign level         = r_level;
  assign wmark_irq     = r_wmark_irq;
  assign ovf_flag      = r_ovf_flag;
  assign ovf_cnt       = r_ovf_cnt;
  assign udf_flag      = r_udf_flag;
  assign busy          = (r_state != ST_IDLE);

endmodule
